matrix_unloader: RTL

MATRIX_UNLOADER -- requirements
Module: matrix_unloader

---
 rtl/mm_pkg.sv | 27 ++
 rtl/matrix_unloader_if.sv | 42 ++++
 rtl/matrix_unloader_idx.sv | 106 ++++++++++
 rtl/matrix_unloader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared constants and types for the matrix unloader block:
//               default element width and matrix dimension, the unloader
//               state encoding and a coordinate-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int MM_W = 32;
    localparam int MM_N = 4;

    // Unloader control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } unl_state_t;

    // Width of a coordinate counter for an n-entry axis (never below 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_unloader_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_unloader_if
// Description : Element stream bus of the matrix unloader. The master drives
//               one element per transfer together with its coordinates and a
//               last marker; the slave accepts with out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_unloader_if
    import mm_pkg::*;
#(
    parameter int W = MM_W,
    parameter int N = MM_N
);

    logic [W-1:0]            out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [idx_width(N)-1:0] out_row;
    logic [idx_width(N)-1:0] out_col;
    logic                    out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/matrix_unloader_idx.sv
`default_nettype none
// ============================================================================
// Module      : matrix_unloader_idx
// Description : Element coordinate generator for the matrix unloader.
//               clear returns to (0,0); advance steps to the next element.
//               Default order is row-major. With MATRIX_UNLOADER_BLOCK_ORDER_EN
//               defined, BLK x BLK tiles are visited in row-major tile order
//               with row-major order inside each tile.
//               Stepping past the final element wraps to (0,0).
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_unloader_idx
    import mm_pkg::*;
#(
    parameter int N = MM_N
`ifdef MATRIX_UNLOADER_BLOCK_ORDER_EN
    ,
    parameter int BLK = 2
`endif
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    clear,
    input  wire logic                    advance,
    output logic [idx_width(N)-1:0]      row,
    output logic [idx_width(N)-1:0]      col,
    output logic                         last
);

    localparam int RW = idx_width(N);
    localparam logic [RW-1:0] COORD_MAX = RW'(N - 1);

    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == COORD_MAX) && (r_col == COORD_MAX);

`ifdef MATRIX_UNLOADER_BLOCK_ORDER_EN
    localparam int BW = idx_width(BLK);
    localparam logic [BW-1:0] IN_MAX = BW'(BLK - 1);
    localparam logic [RW-1:0] BACK   = RW'(BLK - 1);

    // Position inside the current tile
    logic [BW-1:0] r_in_r;
    logic [BW-1:0] r_in_c;

    // Tile-ordered walk: sweep a tile row, drop to the next tile row,
    // then jump to the next tile to the right or to the next tile band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_in_r <= '0;
            r_in_c <= '0;
        end else if (clear || (advance && last)) begin
            r_row  <= '0;
            r_col  <= '0;
            r_in_r <= '0;
            r_in_c <= '0;
        end else if (advance) begin
            if (r_in_c != IN_MAX) begin
                r_in_c <= r_in_c + BW'(1);
                r_col  <= r_col + RW'(1);
            end else begin
                r_in_c <= '0;
                if (r_in_r != IN_MAX) begin
                    r_in_r <= r_in_r + BW'(1);
                    r_row  <= r_row + RW'(1);
                    r_col  <= r_col - BACK;
                end else begin
                    r_in_r <= '0;
                    if (r_col == COORD_MAX) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + RW'(1);
                        r_row <= r_row - BACK;
                    end
                end
            end
        end
    end
`else
    // Row-major walk: column first, wrap to the next row at the right edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear || (advance && last)) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (r_col == COORD_MAX) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + RW'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/matrix_unloader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_unloader
// Description : Captures an N x N matrix of W-bit elements on start and
//               streams it out one element per accepted transfer with
//               valid/ready handshaking, coordinates, a last marker, a
//               done pulse and a modulo-2^W checksum of emitted elements.
//               Optional build macro MATRIX_UNLOADER_BLOCK_ORDER_EN selects
//               BLK x BLK tiled emission order instead of row-major.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_unloader
    import mm_pkg::*;
#(
    parameter int N   = MM_N,
    parameter int W   = MM_W,
    parameter int BLK = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [W*N*N-1:0]  mat_in,
    matrix_unloader_if.master      out_if,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           checksum
);

    localparam int RW = idx_width(N);
    // A capture is only honoured when the tile size divides the matrix
    localparam bit TILING_OK = (BLK > 0) && ((N % BLK) == 0);

    unl_state_t        r_state;
    logic [W*N*N-1:0]  r_buf;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_sum;

    logic [RW-1:0]     w_row;
    logic [RW-1:0]     w_col;
    logic              w_last;
    logic [31:0]       w_sel;
    logic [W-1:0]      w_elem;
    logic              w_go;
    logic              w_xfer;

    assign w_go   = (r_state == ST_IDLE) && start && TILING_OK;
    assign w_xfer = r_valid && out_if.out_ready;

    // Flat element number of the current coordinate inside the buffer
    assign w_sel  = 32'(w_row) * 32'(N) + 32'(w_col);
    assign w_elem = r_buf[w_sel*W +: W];

    matrix_unloader_idx #(
        .N   (N)
`ifdef MATRIX_UNLOADER_BLOCK_ORDER_EN
        ,
        .BLK (BLK)
`endif
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_go),
        .advance (w_xfer),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    // Control FSM: capture on start, stream until the last element is taken,
    // then one FINISH cycle carrying the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_go) begin
                        r_buf   <= mat_in;
                        r_sum   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_sum <= r_sum + w_elem;
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Data is forced to zero whenever nothing is being presented
    assign out_if.out_data  = r_valid ? w_elem : '0;
    assign out_if.out_valid = r_valid;
    assign out_if.out_row   = w_row;
    assign out_if.out_col   = w_col;
    assign out_if.out_last  = r_valid && w_last;

    assign busy     = r_busy;
    assign done     = r_done;
    assign checksum = r_sum;

endmodule
`default_nettype wire
